// File: rtl/prio_queue_scheduler.sv
// ---------------------------------------------------------------------------
// prio_queue_scheduler
//
// N-channel packet scheduler. Each channel owns a small shift FIFO (head at
// entry 0). Each cycle at most one packet is moved from the winning channel's
// head into a registered output stage that hands packets downstream over a
// valid/ready handshake.
//
// Channel selection: the eligible (non-empty) channel with the highest
// priority level wins. Ties go to the lowest index in latency mode (mode=0)
// and to the highest index in reliability mode (mode=1). The mode is
// registered from the rs/ls score comparison and applies one cycle later.
//
// Optional feature, macro SCHED_AGING_EN:
//   Each channel counts loads granted to other channels while it waits.
//   A channel whose count reaches AGE_LIM beats priority. Several aged
//   channels are separated by the normal mode tie rule (index only).
//   Without the macro the arbiter is strict priority.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   per-channel push request
//   in_data_i    per-channel packet, channel c at [c*PW +: PW]
//   in_ready_o   per-channel space available (registered occupancy != DEPTH)
//   prio_i       per-channel priority level, larger = more urgent
//   rs_i, ls_i   reliability / latency scores
//   out_valid_o  output packet valid
//   out_data_o   output packet
//   out_ch_o     source channel of out_data_o
//   out_ready_i  downstream accept
//   occ_o        per-channel occupancy, channel c at [c*CW +: CW]
//   mode_o       0 = latency, 1 = reliability
// ---------------------------------------------------------------------------
// Output stage FSM
//   state    | meaning
//   ST_EMPTY | no packet held, out_valid_o = 0
//   ST_FULL  | packet held in out_data_o/out_ch_o, out_valid_o = 1
// ---------------------------------------------------------------------------
module prio_queue_scheduler #(
   parameter int  NCH     = 4,
   parameter int  DEPTH   = 6,
   parameter int  PW      = 3,
   parameter int  LW      = 3,
   parameter int  SW      = 8,
   parameter int  AGE_LIM = 8,
   localparam int CW      = $clog2(DEPTH + 1),
   localparam int CHW     = $clog2(NCH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NCH-1:0]    in_valid_i,
   input  logic [NCH*PW-1:0] in_data_i,
   output logic [NCH-1:0]    in_ready_o,
   input  logic [NCH*LW-1:0] prio_i,
   input  logic [SW-1:0]     rs_i,
   input  logic [SW-1:0]     ls_i,
   output logic              out_valid_o,
   output logic [PW-1:0]     out_data_o,
   output logic [CHW-1:0]    out_ch_o,
   input  logic              out_ready_i,
   output logic [NCH*CW-1:0] occ_o,
   output logic              mode_o
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   if (NCH < 2 || DEPTH < 1 || AGE_LIM < 1) begin : g_param_check
      $error("prio_queue_scheduler: illegal parameter set");
   end

   logic [NCH-1:0][DEPTH-1:0][PW-1:0] mem_q, mem_d;
   logic [NCH-1:0][CW-1:0]            occ_q, occ_d;
   logic [NCH-1:0][CW-1:0]            wr_idx;
   logic [NCH-1:0]                    elig;
   logic [NCH-1:0]                    cand;
   logic [NCH-1:0]                    push;
   logic [NCH-1:0]                    pop;
   logic                              use_prio;

   logic                              mode_q, mode_d;
   logic [0:0]                        state_q, state_d;
   logic [PW-1:0]                     out_data_q, out_data_d;
   logic [CHW-1:0]                    out_ch_q, out_ch_d;

   logic [CHW-1:0]                    sel;
   logic                              sel_found;
   logic [LW-1:0]                     best_prio;
   logic                              load;

   // ------------------------------------------------------------------
   // Channel status, all from registered occupancy
   // ------------------------------------------------------------------
   always_comb begin
      elig       = '0;
      in_ready_o = '0;
      for (int c = 0; c < NCH; c++) begin
         elig[c]       = (occ_q[c] != '0);
         in_ready_o[c] = (occ_q[c] != CW'(DEPTH));
      end
   end

   // ------------------------------------------------------------------
   // Candidate set: aged channels pre-empt the priority arbitration
   // ------------------------------------------------------------------
`ifdef SCHED_AGING_EN
   localparam int AW = $clog2(AGE_LIM + 1);

   logic [NCH-1:0][AW-1:0] age_q, age_d;
   logic [NCH-1:0]         aged;

   always_comb begin
      aged = '0;
      for (int c = 0; c < NCH; c++) begin
         aged[c] = elig[c] && (age_q[c] == AW'(AGE_LIM));
      end
      use_prio = ~|aged;
      cand     = use_prio ? elig : aged;
   end

   // Counter clears on grant or when the channel drains; otherwise it
   // advances on every load that went elsewhere while this one waited.
   always_comb begin
      age_d = age_q;
      for (int c = 0; c < NCH; c++) begin
         if (pop[c] || (occ_d[c] == '0)) begin
            age_d[c] = '0;
         end else if (load && elig[c] && (age_q[c] != AW'(AGE_LIM))) begin
            age_d[c] = age_q[c] + AW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end
`else
   assign use_prio = 1'b1;
   assign cand     = elig;
`endif

   // ------------------------------------------------------------------
   // Arbiter. Scanning upward, a tie replaces the current winner only in
   // mode 1, which yields lowest index for mode 0 and highest for mode 1.
   // When aged channels are competing, priority is ignored and every
   // candidate counts as a tie.
   // ------------------------------------------------------------------
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      best_prio = '0;
      for (int c = 0; c < NCH; c++) begin
         if (cand[c]) begin
            if (!sel_found
                || (use_prio && (prio_i[c*LW +: LW] > best_prio))
                || ((!use_prio || (prio_i[c*LW +: LW] == best_prio)) && mode_q)) begin
               sel       = CHW'(c);
               sel_found = 1'b1;
               best_prio = prio_i[c*LW +: LW];
            end
         end
      end
   end

   assign load = sel_found && ((state_q == ST_EMPTY) || out_ready_i);

   always_comb begin
      pop  = '0;
      push = '0;
      for (int c = 0; c < NCH; c++) begin
         pop[c]  = load && (sel == CHW'(c));
         push[c] = in_valid_i[c] && in_ready_o[c];
      end
   end

   // ------------------------------------------------------------------
   // Shift FIFOs. A pop shifts every entry down and zeroes the top slot;
   // a simultaneous push lands one slot lower so order is preserved.
   // ------------------------------------------------------------------
   always_comb begin
      mem_d  = mem_q;
      occ_d  = occ_q;
      wr_idx = '0;
      for (int c = 0; c < NCH; c++) begin
         wr_idx[c] = occ_q[c] - CW'(pop[c]);
         if (pop[c]) begin
            for (int e = 0; e < DEPTH - 1; e++) begin
               mem_d[c][e] = mem_q[c][e+1];
            end
            mem_d[c][DEPTH-1] = '0;
         end
         if (push[c]) begin
            for (int e = 0; e < DEPTH; e++) begin
               if (int'(wr_idx[c]) == e) begin
                  mem_d[c][e] = in_data_i[c*PW +: PW];
               end
            end
         end
         occ_d[c] = occ_q[c] + CW'(push[c]) - CW'(pop[c]);
      end
   end

   // ------------------------------------------------------------------
   // Output stage. A held packet is never replaced while stalled.
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      if (load) begin
         state_d    = ST_FULL;
         out_data_d = mem_q[sel][0];
         out_ch_d   = sel;
      end else if ((state_q == ST_FULL) && out_ready_i) begin
         state_d = ST_EMPTY;
      end
   end

   assign mode_d = (rs_i < ls_i) ? 1'b0 : 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q      <= '0;
         occ_q      <= '0;
         mode_q     <= 1'b1;
         state_q    <= ST_EMPTY;
         out_data_q <= '0;
         out_ch_q   <= '0;
      end else begin
         mem_q      <= mem_d;
         occ_q      <= occ_d;
         mode_q     <= mode_d;
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_ch_q   <= out_ch_d;
      end
   end

   assign out_valid_o = (state_q == ST_FULL);
   assign out_data_o  = out_data_q;
   assign out_ch_o    = out_ch_q;
   assign occ_o       = occ_q;
   assign mode_o      = mode_q;

endmodule

// File: tb/tb_prio_queue_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for prio_queue_scheduler. Expected output packets ({ch, data})
// are queued when stimulus is driven and compared when the DUT presents
// them. Inputs are driven and outputs sampled 1 time unit after each rising
// edge. Define SCHED_AGING_EN for both files to exercise the aging variant.
// ---------------------------------------------------------------------------
module tb_prio_queue_scheduler;

   localparam int NCH     = 4;
   localparam int DEPTH   = 6;
   localparam int PW      = 3;
   localparam int LW      = 3;
   localparam int SW      = 8;
   localparam int AGE_LIM = 8;
   localparam int CW      = 3;
   localparam int CHW     = 2;
`ifdef SCHED_AGING_EN
   localparam bit AGING = 1'b1;
`else
   localparam bit AGING = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    in_valid;
   logic [NCH*PW-1:0] in_data;
   logic [NCH-1:0]    in_ready;
   logic [NCH*LW-1:0] prio;
   logic [SW-1:0]     rs;
   logic [SW-1:0]     ls;
   logic              out_valid;
   logic [PW-1:0]     out_data;
   logic [CHW-1:0]    out_ch;
   logic              out_ready;
   logic [NCH*CW-1:0] occ;
   logic              mode;

   int checks   = 0;
   int failures = 0;
   logic [CHW+PW-1:0] exp_q[$];
   logic [CHW+PW-1:0] exp_v;
   logic [CHW+PW-1:0] got_v;

   prio_queue_scheduler #(
      .NCH(NCH), .DEPTH(DEPTH), .PW(PW), .LW(LW), .SW(SW), .AGE_LIM(AGE_LIM)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
      .prio_i(prio), .rs_i(rs), .ls_i(ls),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_ch_o(out_ch),
      .out_ready_i(out_ready), .occ_o(occ), .mode_o(mode)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
   endtask

   task automatic put(input int c, input int d);
      in_valid[c]         = 1'b1;
      in_data[c*PW +: PW] = PW'(d);
   endtask

   task automatic set_prio(input int c, input int p);
      prio[c*LW +: LW] = LW'(p);
   endtask

   function automatic logic [CW-1:0] occ_of(input int c);
      return occ[c*CW +: CW];
   endfunction

   // ------------------------------------------------------------------
   task automatic test_reset();
      idle();
      prio  = '0;
      rs    = '0;
      ls    = '0;
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({out_valid, out_ch, out_data} !== 6'b0) begin
         failures++; $display("FAIL reset_outputs got=%b exp=0", {out_valid, out_ch, out_data});
      end
      checks++;
      if (occ !== '0) begin failures++; $display("FAIL reset_occ got=%h exp=0", occ); end
      checks++;
      if (mode !== 1'b1) begin failures++; $display("FAIL reset_mode got=%b exp=1", mode); end

      rst_n = 1'b1;
      for (int c = 0; c < NCH; c++) put(c, c + 1);
      tick();
      tick();
      // all ties at prio 0 in mode 1 -> channel 3 (data 4) taken first
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 3'd4}) begin
         failures++; $display("FAIL pre_reset_out got=%b exp=%b", {out_valid, out_ch, out_data}, {1'b1, 2'd3, 3'd4});
      end
      checks++;
      if (occ !== {3'd1, 3'd2, 3'd2, 3'd2}) begin
         failures++; $display("FAIL pre_reset_occ got=%h exp=%h", occ, {3'd1, 3'd2, 3'd2, 3'd2});
      end
      idle();
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", out_valid); end
      checks++;
      if (occ !== '0) begin failures++; $display("FAIL async_reset_occ got=%h exp=0", occ); end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({in_ready, out_valid} !== {4'hf, 1'b0}) begin
         failures++; $display("FAIL post_reset_ready got=%b exp=%b", {in_ready, out_valid}, {4'hf, 1'b0});
      end
      exp_q.delete();
   endtask

   // ------------------------------------------------------------------
   task automatic test_fill_drain();
      int cyc;
      idle();
      prio = '0;
      for (int i = 1; i <= 7; i++) begin
         in_valid = '0;
         put(0, i);
         exp_q.push_back({2'd0, PW'(i)});
         tick();
         if (i == 1) begin
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", out_valid); end
         end
         if (i == 2) begin
            checks++;
            if ({out_valid, out_data} !== {1'b1, 3'd1}) begin
               failures++; $display("FAIL latency_one got=%b exp=%b", {out_valid, out_data}, {1'b1, 3'd1});
            end
         end
      end
      checks++;
      if (occ_of(0) !== 3'd6) begin failures++; $display("FAIL fill_occ got=%0d exp=6", occ_of(0)); end
      checks++;
      if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", in_ready[0]); end
      put(0, 0);
      tick();
      in_valid = '0;
      checks++;
      if (occ_of(0) !== 3'd6) begin failures++; $display("FAIL overflow_occ got=%0d exp=6", occ_of(0)); end

      out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 20) begin
         if (out_valid) begin
            exp_v = exp_q.pop_front();
            got_v = {out_ch, out_data};
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL fill_out got=%h exp=%h", got_v, exp_v); end
         end
         tick();
         cyc++;
      end
      checks++;
      if (cyc != 7) begin failures++; $display("FAIL fill_throughput got=%0d exp=7", cyc); end
      checks++;
      if ({out_valid, occ} !== 13'b0) begin
         failures++; $display("FAIL fill_empty got=%b exp=0", {out_valid, occ});
      end
      exp_q.delete();
      idle();
   endtask

   // ------------------------------------------------------------------
   task automatic test_mode();
      int cyc;
      for (int ph = 0; ph < 2; ph++) begin
         idle();
         prio = '0;
         set_prio(1, 5);
         set_prio(2, 5);
         rs = (ph == 0) ? 8'd2 : 8'd9;
         ls = (ph == 0) ? 8'd9 : 8'd2;
         tick();
         checks++;
         if (mode !== ph[0]) begin failures++; $display("FAIL mode_reg got=%b exp=%b", mode, ph[0]); end
         put(1, (ph == 0) ? 3 : 2);
         put(2, (ph == 0) ? 6 : 5);
         if (ph == 0) begin
            exp_q.push_back({2'd1, 3'd3});
            exp_q.push_back({2'd2, 3'd6});
         end else begin
            exp_q.push_back({2'd2, 3'd5});
            exp_q.push_back({2'd1, 3'd2});
         end
         tick();
         in_valid = '0;
         tick();
         checks++;
         if (out_ch !== ((ph == 0) ? 2'd1 : 2'd2)) begin
            failures++; $display("FAIL mode_tie_sel got=%0d exp=%0d", out_ch, (ph == 0) ? 1 : 2);
         end
         out_ready = 1'b1;
         cyc = 0;
         while (exp_q.size() > 0 && cyc < 20) begin
            if (out_valid) begin
               exp_v = exp_q.pop_front();
               got_v = {out_ch, out_data};
               checks++;
               if (got_v !== exp_v) begin failures++; $display("FAIL mode_out got=%h exp=%h", got_v, exp_v); end
            end
            tick();
            cyc++;
         end
         checks++;
         if (exp_q.size() != 0) begin
            failures++; $display("FAIL mode_drain left=%0d exp=0", exp_q.size()); exp_q.delete();
         end
      end
      idle();
   endtask

   // ------------------------------------------------------------------
   task automatic test_prio();
      int cyc;
      idle();
      prio = '0;
      set_prio(3, 7);
      set_prio(0, 1);
      for (int i = 0; i < 3; i++) begin
         in_valid = '0;
         put(0, i);
         put(3, i + 4);
         tick();
      end
      in_valid = '0;
      for (int i = 0; i < 3; i++) exp_q.push_back({2'd3, PW'(i + 4)});
      for (int i = 0; i < 3; i++) exp_q.push_back({2'd0, PW'(i)});
      checks++;
      if ({occ_of(3), occ_of(0)} !== {3'd2, 3'd3}) begin
         failures++; $display("FAIL prio_occ got=%h exp=%h", {occ_of(3), occ_of(0)}, {3'd2, 3'd3});
      end
      out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 20) begin
         if (out_valid) begin
            exp_v = exp_q.pop_front();
            got_v = {out_ch, out_data};
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL prio_out got=%h exp=%h", got_v, exp_v); end
         end
         tick();
         cyc++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL prio_drain left=%0d exp=0", exp_q.size()); exp_q.delete();
      end
      idle();
   endtask

   // ------------------------------------------------------------------
   task automatic test_stall();
      idle();
      prio = '0;
      set_prio(1, 7);
      put(1, 1);
      put(0, 7);
      tick();
      in_valid = '0;
      put(1, 2);
      tick();
      in_valid = '0;
      put(1, 3);
      tick();
      in_valid = '0;
      for (int i = 0; i < 5; i++) begin
         prio = 12'($urandom());
         tick();
         checks++;
         if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 3'd1}) begin
            failures++; $display("FAIL stall_hold got=%b exp=%b", {out_valid, out_ch, out_data}, {1'b1, 2'd1, 3'd1});
         end
      end
      prio = '0;
      set_prio(1, 7);
      for (int i = 1; i <= 5; i++) exp_q.push_back({2'd1, PW'(i)});
      exp_q.push_back({2'd0, 3'd7});
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
         in_valid  = '0;
         out_ready = 1'b1;
         if (k < 2) put(1, 4 + k);
         if (out_valid) begin
            exp_v = exp_q.pop_front();
            got_v = {out_ch, out_data};
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL stall_out got=%h exp=%h", got_v, exp_v); end
         end
         tick();
         if (k < 2) begin
            checks++;
            if (occ_of(1) !== 3'd2) begin failures++; $display("FAIL pushpop_occ got=%0d exp=2", occ_of(1)); end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL stall_drain left=%0d exp=0", exp_q.size()); exp_q.delete();
      end
      idle();
   endtask

   // ------------------------------------------------------------------
   // ch1 (prio 7) refilled every cycle; ch0 (prio 0) gets one packet at
   // slot 2. Its 9th load while eligible shows up at slot 12 when aging
   // is built in; otherwise it only leaves once ch1 runs dry.
   // ------------------------------------------------------------------
   task automatic test_aging();
      idle();
      prio = '0;
      set_prio(1, 7);
      out_ready = 1'b1;
      for (int s = 0; s < 60; s++) begin
         in_valid = '0;
         if (out_valid) begin
            got_v = {out_ch, out_data};
            if (AGING && s == 12) begin
               exp_v = {2'd0, 3'd5};
            end else if (exp_q.size() > 0) begin
               exp_v = exp_q.pop_front();
            end else begin
               exp_v = 'x;
            end
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL aging_out slot=%0d got=%h exp=%h", s, got_v, exp_v); end
         end
         if (s < 16) begin
            put(1, s % 8);
            exp_q.push_back({2'd1, PW'(s % 8)});
         end
         if (s == 2) put(0, 5);
         if (!AGING && s == 16) exp_q.push_back({2'd0, 3'd5});
         tick();
         if (s > 16 && exp_q.size() == 0 && !out_valid) break;
      end
      in_valid = '0;
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL aging_drain left=%0d exp=0", exp_q.size()); exp_q.delete();
      end
      checks++;
      if ({out_valid, occ} !== 13'b0) begin
         failures++; $display("FAIL aging_empty got=%b exp=0", {out_valid, occ});
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_mode();
      test_prio();
      test_stall();
      test_aging();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
